ysyx_22040237_exu_ctrl: RTL

YSYX_22040237_EXU_CTRL -- requirements
Module: ysyx_22040237_exu_ctrl

---
 rtl/ysyx_22040237_exu_ctrl_pkg.sv | 22 ++
 rtl/ysyx_22040237_exu_tmo_cnt.sv | 31 +++
 rtl/ysyx_22040237_exu_ctrl.sv | 110 +++++++++++
 3 files changed

// File: rtl/ysyx_22040237_exu_ctrl_pkg.sv
// Shared types and constants for the EXU controller.
// FSM states, halt codes, MD class bit and timeout default.
package ysyx_22040237_exu_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ALU,
    ST_MD_WAIT,
    ST_RESP,
    ST_HALT
  } state_t;

  localparam logic [1:0] HC_NONE    = 2'd0;
  localparam logic [1:0] HC_EBREAK  = 2'd1;
  localparam logic [1:0] HC_INVALID = 2'd2;
  localparam logic [1:0] HC_TIMEOUT = 2'd3;

  localparam int MD_BIT         = 7;
  localparam int MD_TIMEOUT_DEF = 80;
  localparam int CNT_W          = 7;

endpackage

// File: rtl/ysyx_22040237_exu_tmo_cnt.sv
// Saturating MD wait counter with terminal-count flag.
// Clear wins over enable; the count never wraps.
module ysyx_22040237_exu_tmo_cnt
  import ysyx_22040237_exu_ctrl_pkg::*;
#(
  parameter int LIMIT = MD_TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic terminal
);

  localparam logic [CNT_W-1:0] TERM = CNT_W'(LIMIT - 1);
  localparam logic [CNT_W-1:0] SAT  = '1;

  logic [CNT_W-1:0] cnt;

  assign terminal = (cnt == TERM);

  // Count waiting cycles, holding at the maximum value.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (enable && cnt != SAT) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/ysyx_22040237_exu_ctrl.sv
// EXU controller: dispatches ALU / MD ops, handshakes to WBU,
// and raises a sticky halt on ebreak, invalid op or MD timeout.
module ysyx_22040237_exu_ctrl
  import ysyx_22040237_exu_ctrl_pkg::*;
#(
  parameter int MD_TIMEOUT = MD_TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_opcode,
  input  logic        in_ebreak,
  input  logic        in_invalid,
  input  logic [63:0] alu_result,
  output logic        md_start,
  input  logic        md_done,
  input  logic [63:0] md_result,
  output logic [7:0]  op_opcode,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_rd_data,
  output logic        halt,
  output logic [1:0]  halt_code
);

  state_t state;
  logic   xfer;
  logic   tmo_en;
  logic   tmo_term;

  assign in_ready = (state == ST_IDLE) && !rst;
  assign xfer     = in_valid && in_ready;
  assign tmo_en   = (state == ST_MD_WAIT) && !md_done;

  ysyx_22040237_exu_tmo_cnt #(
    .LIMIT(MD_TIMEOUT)
  ) u_tmo (
    .clk     (clk),
    .rst     (rst),
    .clear   (xfer),
    .enable  (tmo_en),
    .terminal(tmo_term)
  );

  // Main control FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      md_start    <= 1'b0;
      op_opcode   <= 8'h0;
      out_valid   <= 1'b0;
      out_rd_data <= 64'h0;
      halt        <= 1'b0;
      halt_code   <= HC_NONE;
    end else begin
      md_start <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (xfer) begin
            op_opcode <= in_opcode;
            if (in_ebreak) begin
              state     <= ST_HALT;
              halt      <= 1'b1;
              halt_code <= HC_EBREAK;
            end else if (in_invalid) begin
              state     <= ST_HALT;
              halt      <= 1'b1;
              halt_code <= HC_INVALID;
            end else if (in_opcode[MD_BIT]) begin
              state    <= ST_MD_WAIT;
              md_start <= 1'b1;
            end else begin
              state <= ST_ALU;
            end
          end
        end
        ST_ALU: begin
          out_rd_data <= alu_result;
          out_valid   <= 1'b1;
          state       <= ST_RESP;
        end
        ST_MD_WAIT: begin
          if (md_done) begin
            out_rd_data <= md_result;
            out_valid   <= 1'b1;
            state       <= ST_RESP;
          end else if (tmo_term) begin
            state     <= ST_HALT;
            halt      <= 1'b1;
            halt_code <= HC_TIMEOUT;
          end
        end
        ST_RESP: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        ST_HALT: begin
          state <= ST_HALT;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
